rx_packet_parser: RTL and testbench
===================================

RX_PACKET_PARSER -- requirements
Module: rx_packet_parser

Interface
REQ-001 SHALL have parameter MAX_LEN, default 4, maximum payload bytes accepted per frame.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 50000, idle CLOCK_50 cycles between bytes (1 ms at 50 MHz) before a partial frame is abandoned.
REQ-003 SHALL have CLOCK_50  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have RESET  input  1  asynchronous, active-high reset.
REQ-005 SHALL have RX_DATA  input  8  received byte from the UART; valid only while RX_RECV=1.
REQ-006 SHALL have RX_RECV  input  1  one-cycle strobe per received byte.
REQ-007 SHALL have PKT_CMD  output  8  command byte of the last good frame.
REQ-008 SHALL have PKT_LEN  output  8  payload length of the last good frame.
REQ-009 SHALL have PKT_DATA  output  8*MAX_LEN  payload; first received byte in [7:0], next in [15:8], and so on; unused bytes zero.
REQ-010 SHALL have PKT_VALID  output  1  one-cycle pulse per good frame.
REQ-011 SHALL have PKT_ERR  output  1  one-cycle pulse per abandoned frame.
REQ-012 SHALL have ERR_CODE  output  2  cause of the last PKT_ERR: 1 = length too big, 2 = timeout; 0 = none since reset.

Function
REQ-013 Frame format SHALL be 0xFF start, CMD, LEN, then LEN data bytes; no escaping.
REQ-014 FSM states SHALL be IDLE, GET_CMD, GET_LEN, GET_DATA.
REQ-015 IDLE: a byte equal to 0xFF SHALL move to GET_CMD; any other byte SHALL be discarded silently.
REQ-016 GET_CMD: any byte, 0xFF included, SHALL be latched internally as the command, then move to GET_LEN.
REQ-017 GET_LEN, LEN=0: SHALL complete the frame immediately and return to IDLE.
REQ-018 GET_LEN, LEN>MAX_LEN: SHALL pulse PKT_ERR with ERR_CODE=1 and return to IDLE.
REQ-019 GET_LEN, otherwise: SHALL clear the byte index and the staging buffer, then move to GET_DATA.
REQ-020 GET_DATA: each byte, 0xFF included, SHALL be stored at the current index, which then increments; on the LEN-th byte the frame SHALL complete and return to IDLE.
REQ-021 Completion SHALL copy the staged command, length and payload to PKT_CMD/PKT_LEN/PKT_DATA and pulse PKT_VALID in the cycle after the final byte's RX_RECV cycle (latency 1).
REQ-022 PKT_CMD/PKT_LEN/PKT_DATA SHALL hold their values until the next completion; an error SHALL NOT alter them.
REQ-023 The timeout counter SHALL clear on every RX_RECV and in IDLE; it SHALL increment each cycle in any other state.
REQ-024 When the timeout counter reaches TIMEOUT_CYCLES outside IDLE, the block SHALL pulse PKT_ERR with ERR_CODE=2 and return to IDLE.
REQ-025 If RX_RECV coincides with the timeout cycle, the byte SHALL win: it is processed and the counter clears.
REQ-026 The payload index SHALL never exceed MAX_LEN-1; bytes beyond MAX_LEN SHALL be unreachable by construction (REQ-018).
REQ-027 PKT_VALID and PKT_ERR SHALL never assert in the same cycle.
REQ-028 Back-to-back frames with no gap SHALL be accepted; a 0xFF arriving in the cycle after completion SHALL start a new frame.

Reset
REQ-029 RESET SHALL force state IDLE, clear the index, timeout counter and staging buffer, and set every output to 0, independent of CLOCK_50.
REQ-030 RESET asserted mid-frame SHALL discard the partial frame without a PKT_ERR pulse.

Structure
REQ-031 The frame start value (0xFF), the error codes and the FSM state encodings SHALL live in a shared package/include also used by the transmit framer.
REQ-032 The timeout counter SHALL be one sub-module, rx_gap_timer (inputs clear, enable; output expired).
REQ-033 The block SHALL be instantiated beside uart, taking RX_DATA/RX_RECV directly.

Verification
REQ-034 FF 01 03 AA BB CC -> one PKT_VALID, PKT_CMD=01, PKT_LEN=3, PKT_DATA=0x00CCBBAA.
REQ-035 12 34 FF 00 00 -> no output for 12 and 34; then PKT_VALID with CMD=00, LEN=0, DATA=0.
REQ-036 FF 04 05 -> PKT_ERR with ERR_CODE=1; the earlier PKT_* values are unchanged.
REQ-037 FF 01 02 11, then 50000 idle cycles -> PKT_ERR with ERR_CODE=2 exactly 50000 cycles after the 11 strobe; a following FF 01 01 FF -> PKT_VALID with DATA=0x000000FF.
REQ-038 RESET pulse after FF 01 02 11, then 22 33 -> no PKT_VALID and no PKT_ERR; all outputs 0.
REQ-039 Two frames FF 00 01 AA and FF 01 01 BB with consecutive RX_RECV strobes -> two PKT_VALID pulses, second showing CMD=01, DATA=0xBB.

Source files
------------

// File: rtl/rx_packet_parser_pkg.sv
// Shared framing definitions for the UART packet receive parser and transmit framer.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
//
// Contents:
//   FRAME_START      - byte value that opens every frame
//   err_code_e       - cause reported on ERR_CODE after an abandoned frame
//   parser_state_e   - receive parser FSM encodings
package rx_packet_parser_pkg;

    localparam logic [7:0] FRAME_START = 8'hFF;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_LEN     = 2'd1,
        ERR_TIMEOUT = 2'd2
    } err_code_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_GET_CMD  = 2'd1,
        ST_GET_LEN  = 2'd2,
        ST_GET_DATA = 2'd3
    } parser_state_e;

endpackage

// File: rtl/rx_gap_timer.sv
// Inter-byte gap timer: flags when a partial frame has sat idle for TIMEOUT_CYCLES cycles.
// Latency: expired is combinational from the count register; it asserts in the
// TIMEOUT_CYCLES-th enabled cycle after the last clear. Backpressure: none.
//
// Ports:
//   clk_i    - clock (rising edge)
//   rst_i    - asynchronous active-high reset
//   clear    - zero the count (has priority over enable)
//   enable   - count this cycle
//   expired  - the count reaches TIMEOUT_CYCLES at the coming edge
module rx_gap_timer #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // count_q holds the number of idle cycles already completed, so the cycle
    // in which it equals TIMEOUT_CYCLES-1 is the final idle cycle of the gap.
    assign expired = enable && !clear && (count_q == LAST_CNT);

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && !expired) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/rx_packet_parser.sv
// Parses 0xFF / CMD / LEN / DATA[LEN] frames from a UART byte stream.
// Latency: PKT_VALID / PKT_ERR pulse one cycle after the deciding RX_RECV cycle
// (timeout: the cycle after TIMEOUT_CYCLES idle cycles). Backpressure: none; every strobe is consumed.
//
// Ports:
//   CLOCK_50  - sole clock          RESET    - asynchronous active-high reset
//   RX_DATA   - received byte       RX_RECV  - one-cycle strobe per byte
//   PKT_CMD / PKT_LEN / PKT_DATA    - last good frame (held until the next one)
//   PKT_VALID - good-frame pulse    PKT_ERR  - abandoned-frame pulse
//   ERR_CODE  - cause of the last PKT_ERR (0 none, 1 length, 2 timeout)
module rx_packet_parser
    import rx_packet_parser_pkg::*;
#(
    parameter int MAX_LEN        = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                 CLOCK_50,
    input  logic                 RESET,
    input  logic [7:0]           RX_DATA,
    input  logic                 RX_RECV,
    output logic [7:0]           PKT_CMD,
    output logic [7:0]           PKT_LEN,
    output logic [8*MAX_LEN-1:0] PKT_DATA,
    output logic                 PKT_VALID,
    output logic                 PKT_ERR,
    output logic [1:0]           ERR_CODE
);

    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [8:0] MAX_LEN_W = 9'(MAX_LEN);

    parser_state_e        state_q, state_d;
    logic [7:0]           cmd_q, cmd_d;
    logic [7:0]           len_q, len_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [8*MAX_LEN-1:0] stage_q, stage_d;

    logic [7:0]           pkt_cmd_q, pkt_cmd_d;
    logic [7:0]           pkt_len_q, pkt_len_d;
    logic [8*MAX_LEN-1:0] pkt_data_q, pkt_data_d;
    logic                 pkt_valid_q, pkt_valid_d;
    logic                 pkt_err_q, pkt_err_d;
    logic [1:0]           err_code_q, err_code_d;

    logic                 gap_clear;
    logic                 gap_enable;
    logic                 gap_expired;
    logic [8*MAX_LEN-1:0] stage_wr;
    logic                 last_byte;

    // A byte strobe always restarts the gap, which is also how a byte landing
    // in the expiry cycle wins over the timeout.
    assign gap_clear  = RX_RECV || (state_q == ST_IDLE);
    assign gap_enable = (state_q != ST_IDLE);

    rx_gap_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_gap_timer (
        .clk_i   (CLOCK_50),
        .rst_i   (RESET),
        .clear   (gap_clear),
        .enable  (gap_enable),
        .expired (gap_expired)
    );

    // Staging buffer with the incoming byte merged at the current index, so the
    // final byte can be copied to PKT_DATA in the same edge it is stored.
    always_comb begin
        stage_wr = stage_q;
        for (int b = 0; b < MAX_LEN; b++) begin
            if (idx_q == IDX_W'(b)) begin
                stage_wr[b*8 +: 8] = RX_DATA;
            end
        end
    end

    assign last_byte = ((8'(idx_q) + 8'd1) == len_q);

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        len_d       = len_q;
        idx_d       = idx_q;
        stage_d     = stage_q;
        pkt_cmd_d   = pkt_cmd_q;
        pkt_len_d   = pkt_len_q;
        pkt_data_d  = pkt_data_q;
        pkt_valid_d = 1'b0;
        pkt_err_d   = 1'b0;
        err_code_d  = err_code_q;

        case (state_q)
            ST_IDLE: begin
                if (RX_RECV && (RX_DATA == FRAME_START)) begin
                    state_d = ST_GET_CMD;
                end
            end

            ST_GET_CMD: begin
                if (RX_RECV) begin
                    cmd_d   = RX_DATA;
                    state_d = ST_GET_LEN;
                end
            end

            ST_GET_LEN: begin
                if (RX_RECV) begin
                    if (RX_DATA == 8'd0) begin
                        pkt_cmd_d   = cmd_q;
                        pkt_len_d   = 8'd0;
                        pkt_data_d  = '0;
                        pkt_valid_d = 1'b1;
                        state_d     = ST_IDLE;
                    end else if ({1'b0, RX_DATA} > MAX_LEN_W) begin
                        pkt_err_d  = 1'b1;
                        err_code_d = ERR_LEN;
                        state_d    = ST_IDLE;
                    end else begin
                        len_d   = RX_DATA;
                        idx_d   = '0;
                        stage_d = '0;
                        state_d = ST_GET_DATA;
                    end
                end
            end

            ST_GET_DATA: begin
                if (RX_RECV) begin
                    stage_d = stage_wr;
                    if (last_byte) begin
                        pkt_cmd_d   = cmd_q;
                        pkt_len_d   = len_q;
                        pkt_data_d  = stage_wr;
                        pkt_valid_d = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        // LEN <= MAX_LEN, so this never steps past MAX_LEN-1.
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // gap_expired already implies no strobe and a non-IDLE state.
        if (gap_expired) begin
            pkt_err_d  = 1'b1;
            err_code_d = ERR_TIMEOUT;
            state_d    = ST_IDLE;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            cmd_q       <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            stage_q     <= '0;
            pkt_cmd_q   <= '0;
            pkt_len_q   <= '0;
            pkt_data_q  <= '0;
            pkt_valid_q <= 1'b0;
            pkt_err_q   <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            stage_q     <= stage_d;
            pkt_cmd_q   <= pkt_cmd_d;
            pkt_len_q   <= pkt_len_d;
            pkt_data_q  <= pkt_data_d;
            pkt_valid_q <= pkt_valid_d;
            pkt_err_q   <= pkt_err_d;
            err_code_q  <= err_code_d;
        end
    end

    assign PKT_CMD   = pkt_cmd_q;
    assign PKT_LEN   = pkt_len_q;
    assign PKT_DATA  = pkt_data_q;
    assign PKT_VALID = pkt_valid_q;
    assign PKT_ERR   = pkt_err_q;
    assign ERR_CODE  = err_code_q;

endmodule

// File: tb/tb_rx_packet_parser.sv
// Directed-vector bench for rx_packet_parser with a queue-based scoreboard.
module tb_rx_packet_parser;

    localparam int MAX_LEN        = 4;
    localparam int TIMEOUT_CYCLES = 50000;

    logic                 clk;
    logic                 rst;
    logic [7:0]           rx_data;
    logic                 rx_recv;
    logic [7:0]           pkt_cmd;
    logic [7:0]           pkt_len;
    logic [8*MAX_LEN-1:0] pkt_data;
    logic                 pkt_valid;
    logic                 pkt_err;
    logic [1:0]           err_code;

    rx_packet_parser #(
        .MAX_LEN        (MAX_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .CLOCK_50  (clk),
        .RESET     (rst),
        .RX_DATA   (rx_data),
        .RX_RECV   (rx_recv),
        .PKT_CMD   (pkt_cmd),
        .PKT_LEN   (pkt_len),
        .PKT_DATA  (pkt_data),
        .PKT_VALID (pkt_valid),
        .PKT_ERR   (pkt_err),
        .ERR_CODE  (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         is_err;
        logic [7:0] cmd;
        logic [7:0] len;
        logic [31:0] data;
        logic [1:0] code;
        int         at_cyc;   // -1: arrival cycle not checked
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   last_strobe = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic exp_t mk(input bit is_err, input logic [7:0] cmd, input logic [7:0] len,
                                input logic [31:0] data, input logic [1:0] code, input int at_cyc);
        exp_t e;
        e.is_err = is_err;
        e.cmd    = cmd;
        e.len    = len;
        e.data   = data;
        e.code   = code;
        e.at_cyc = at_cyc;
        return e;
    endfunction

    // Monitor: every output pulse is matched against the head of the queue.
    always @(negedge clk) begin
        if (!rst && (pkt_valid || pkt_err)) begin
            chk("valid_err_exclusive", 64'(pkt_valid && pkt_err), 64'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_output", 64'({pkt_valid, pkt_err}), 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("pulse_kind_err", 64'(pkt_err), 64'(mon_e.is_err));
                chk("pkt_cmd", 64'(pkt_cmd), 64'(mon_e.cmd));
                chk("pkt_len", 64'(pkt_len), 64'(mon_e.len));
                chk("pkt_data", 64'(pkt_data), 64'(mon_e.data));
                chk("err_code", 64'(err_code), 64'(mon_e.code));
                if (mon_e.at_cyc >= 0) begin
                    chk("pulse_cycle", 64'(cyc), 64'(mon_e.at_cyc));
                end
            end
        end
    end

    // Entered and left #1 after a rising edge, so consecutive calls strobe on consecutive cycles.
    task automatic send(input logic [7:0] b);
        rx_data     = b;
        rx_recv     = 1'b1;
        last_strobe = cyc;
        @(posedge clk);
        #1;
        rx_recv = 1'b0;
        rx_data = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain(input int bound);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            chk("drain_timeout_pending", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
        idle(2);
    endtask

    initial begin
        rst     = 1'b1;
        rx_data = 8'h00;
        rx_recv = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {pkt_cmd, pkt_len, pkt_data, pkt_valid, pkt_err, err_code}, 64'd0);
        rst = 1'b0;
        idle(2);

        // Basic 3-byte frame.
        exp_q.push_back(mk(1'b0, 8'h01, 8'h03, 32'h00CCBBAA, 2'd0, -1));
        send(8'hFF); send(8'h01); send(8'h03); send(8'hAA); send(8'hBB); send(8'hCC);
        wait_drain(20);

        // Length 5 > MAX_LEN: error, previous frame fields held.
        exp_q.push_back(mk(1'b1, 8'h01, 8'h03, 32'h00CCBBAA, 2'd1, -1));
        send(8'hFF); send(8'h04); send(8'h05);
        wait_drain(20);

        // Junk before start, then a zero-length frame.
        exp_q.push_back(mk(1'b0, 8'h00, 8'h00, 32'h0, 2'd1, -1));
        send(8'h12); send(8'h34); send(8'hFF); send(8'h00); send(8'h00);
        wait_drain(20);

        // Maximum length with 0xFF as a data byte.
        exp_q.push_back(mk(1'b0, 8'h7E, 8'h04, 32'h030201FF, 2'd1, -1));
        send(8'hFF); send(8'h7E); send(8'h04); send(8'hFF); send(8'h01); send(8'h02); send(8'h03);
        wait_drain(20);

        // Partial frame then a full idle gap: error one cycle after the last of
        // TIMEOUT_CYCLES idle cycles following the 0x11 strobe cycle.
        send(8'hFF); send(8'h01); send(8'h02); send(8'h11);
        exp_q.push_back(mk(1'b1, 8'h7E, 8'h04, 32'h030201FF, 2'd2,
                           last_strobe + TIMEOUT_CYCLES + 1));
        wait_drain(TIMEOUT_CYCLES + 100);
        exp_q.push_back(mk(1'b0, 8'h01, 8'h01, 32'h000000FF, 2'd2, -1));
        send(8'hFF); send(8'h01); send(8'h01); send(8'hFF);
        wait_drain(20);

        // Two frames with no gap between strobes.
        exp_q.push_back(mk(1'b0, 8'h00, 8'h01, 32'h000000AA, 2'd2, -1));
        exp_q.push_back(mk(1'b0, 8'h01, 8'h01, 32'h000000BB, 2'd2, -1));
        send(8'hFF); send(8'h00); send(8'h01); send(8'hAA);
        send(8'hFF); send(8'h01); send(8'h01); send(8'hBB);
        wait_drain(20);

        // Asynchronous reset mid-frame: outputs clear before any clock edge,
        // and the trailing bytes must not complete the abandoned frame.
        send(8'hFF); send(8'h01); send(8'h02); send(8'h11);
        #3;
        rst = 1'b1;
        #1;
        chk("async_reset_outputs", {pkt_cmd, pkt_len, pkt_data, pkt_valid, pkt_err, err_code}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(1);
        send(8'h22); send(8'h33);
        idle(5);
        chk("post_reset_outputs", {pkt_cmd, pkt_len, pkt_data, pkt_valid, pkt_err, err_code}, 64'd0);

        wait_drain(10);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
